// File: rtl/wb_rr_interconnect_if.sv
// Bus bundle between NUM_MASTERS upstream Wishbone masters, the round-robin
// interconnect and its single downstream (l2) slave port.
interface wb_rr_interconnect_if #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 12
);
  localparam int SEL_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0]        m_cyc;
  logic [NUM_MASTERS-1:0]        m_stb;
  logic [NUM_MASTERS-1:0]        m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] m_adr;
  logic [NUM_MASTERS*SEL_W-1:0]  m_sel;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_m;
  logic [NUM_MASTERS-1:0]        m_ack;
  logic [NUM_MASTERS-1:0]        m_rty;
  logic [NUM_MASTERS*DATA_W-1:0] m_dat_s;

  logic                          l2_cyc;
  logic                          l2_stb;
  logic                          l2_we;
  logic [ADDR_W-1:0]             l2_adr;
  logic [SEL_W-1:0]              l2_sel;
  logic [DATA_W-1:0]             l2_dat_m;
  logic                          l2_ack;
  logic                          l2_rty;
  logic [DATA_W-1:0]             l2_dat_s;

  logic [NUM_MASTERS-1:0]        gnt;

  // The interconnect is the slave of the upstream masters and the master of l2.
  modport slave (
    input  m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m, l2_ack, l2_rty, l2_dat_s,
    output m_ack, m_rty, m_dat_s, l2_cyc, l2_stb, l2_we, l2_adr, l2_sel, l2_dat_m, gnt
  );

  modport master (
    output m_cyc, m_stb, m_we, m_adr, m_sel, m_dat_m, l2_ack, l2_rty, l2_dat_s,
    input  m_ack, m_rty, m_dat_s, l2_cyc, l2_stb, l2_we, l2_adr, l2_sel, l2_dat_m, gnt
  );
endinterface

// File: rtl/wb_rr_interconnect.sv
// Round-robin Wishbone N:1 interconnect (IDLE -> SETUP -> CONNECT).
// Optional watchdog on a stalled CONNECT is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_interconnect #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_W         = 128,
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_rr_interconnect_if.slave  bus
);
  localparam int SEL_W = DATA_W / 8;
  localparam int IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, CONNECT} state_t;

  state_t                 state;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          last_grant;
  logic [NUM_MASTERS-1:0] gnt_r;
  logic [NUM_MASTERS-1:0] req;
  logic [IW:0]            pick_idle;
  logic [IW:0]            pick_next;
  logic                   conn;
  logic                   to_hit;
  logic                   live;
  logic                   done;

  // Returns {found, index}: first requester strictly after 'last', wrapping.
  function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] r,
                                          input logic [IW-1:0] last);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_MASTERS);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req       = bus.m_cyc & bus.m_stb;
  assign pick_idle = rr_pick(req, last_grant);
  assign pick_next = rr_pick(req & ~(NUM_MASTERS'(1) << gidx), gidx);
  assign conn      = (state == CONNECT);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  assign to_hit = conn && (to_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign to_hit = 1'b0;
`endif

  assign live = conn && !to_hit;
  assign done = live && (bus.l2_ack || bus.l2_rty);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gidx       <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
      gnt_r      <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[IW]) begin
            gidx  <= pick_idle[IW-1:0];
            state <= SETUP;
          end
        end
        SETUP: begin
          state <= CONNECT;
          gnt_r <= NUM_MASTERS'(1) << gidx;
`ifdef WB_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        CONNECT: begin
          // Watchdog has precedence: l2 sees cyc low that cycle, so any ack is void.
          if (to_hit) begin
            last_grant <= gidx;
            gnt_r      <= '0;
            state      <= IDLE;
          end else if (done) begin
            last_grant <= gidx;
            gnt_r      <= '0;
            if (pick_next[IW]) begin
              gidx  <= pick_next[IW-1:0];
              state <= SETUP;
            end else begin
              state <= IDLE;
            end
          end else if (!bus.m_cyc[gidx]) begin
            gnt_r <= '0;
            state <= IDLE;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.l2_cyc   = 1'b0;
    bus.l2_stb   = 1'b0;
    bus.l2_we    = 1'b0;
    bus.l2_adr   = '0;
    bus.l2_sel   = '0;
    bus.l2_dat_m = '0;
    bus.m_ack    = '0;
    bus.m_rty    = '0;
    bus.m_dat_s  = '0;
    if (live) begin
      bus.l2_cyc   = bus.m_cyc[gidx];
      bus.l2_stb   = bus.m_stb[gidx];
      bus.l2_we    = bus.m_we[gidx];
      bus.l2_adr   = bus.m_adr[gidx*ADDR_W +: ADDR_W];
      bus.l2_sel   = bus.m_sel[gidx*SEL_W +: SEL_W];
      bus.l2_dat_m = bus.m_dat_m[gidx*DATA_W +: DATA_W];
      bus.m_ack[gidx] = bus.l2_ack;
      bus.m_rty[gidx] = bus.l2_rty;
      bus.m_dat_s[gidx*DATA_W +: DATA_W] = bus.l2_dat_s;
    end
    if (to_hit) bus.m_rty[gidx] = 1'b1;
  end

  assign bus.gnt = gnt_r;

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Directed bench for wb_rr_interconnect with a transaction-level arbiter model
// compared every cycle, plus literal checks of the key scenarios.
module tb_wb_rr_interconnect;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  wb_rr_interconnect_if #(.NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_rr_interconnect #(
    .NUM_MASTERS(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string name, input logic [N*DW-1:0] act,
                     input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc    = '0;
    bus.m_stb    = '0;
    bus.m_we     = '0;
    bus.m_adr    = '0;
    bus.m_sel    = '0;
    bus.m_dat_m  = '0;
    bus.l2_ack   = 1'b0;
    bus.l2_rty   = 1'b0;
    bus.l2_dat_s = '0;
  endtask

  // Master i presents address 0x101+16*i, sel 0xF>>i, data 0xD0000000+i.
  task automatic req(input int i, input logic on, input logic we);
    bus.m_cyc[i]              = on;
    bus.m_stb[i]              = on;
    bus.m_we[i]               = we;
    bus.m_adr[i*AW +: AW]     = AW'(32'h101 + i * 16);
    bus.m_sel[i*SW +: SW]     = SW'(4'hF >> i);
    bus.m_dat_m[i*DW +: DW]   = 32'hD000_0000 + i;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pick(input logic [N-1:0] r, input int after, input int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (after + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  logic            e_cyc, e_stb, e_we;
  logic [AW-1:0]   e_adr;
  logic [SW-1:0]   e_sel;
  logic [DW-1:0]   e_dm;
  logic [N-1:0]    e_ack, e_rty, e_gnt;
  logic [N*DW-1:0] e_ds;
  bit              md_conn  = 1'b0;
  bit              md_setup = 1'b0;
  bit              md_to;
  int              md_own   = 0;
  int              md_last  = N - 1;
  int              md_cnt   = 0;
  int              md_w;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        md_to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        md_to = md_conn && (md_cnt == TO);
`endif
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_sel = '0; e_dm = '0;
        e_ack = '0; e_rty = '0; e_gnt = '0; e_ds = '0;
        if (md_conn) begin
          e_gnt[md_own] = 1'b1;
          if (md_to) begin
            e_rty[md_own] = 1'b1;
          end else begin
            e_cyc = bus.m_cyc[md_own];
            e_stb = bus.m_stb[md_own];
            e_we  = bus.m_we[md_own];
            e_adr = bus.m_adr[md_own*AW +: AW];
            e_sel = bus.m_sel[md_own*SW +: SW];
            e_dm  = bus.m_dat_m[md_own*DW +: DW];
            e_ack[md_own] = bus.l2_ack;
            e_rty[md_own] = bus.l2_rty;
            e_ds[md_own*DW +: DW] = bus.l2_dat_s;
          end
        end
        chk("mdl_l2_cyc", bus.l2_cyc, e_cyc);
        chk("mdl_l2_stb", bus.l2_stb, e_stb);
        chk("mdl_l2_we", bus.l2_we, e_we);
        chk("mdl_l2_adr", bus.l2_adr, e_adr);
        chk("mdl_l2_sel", bus.l2_sel, e_sel);
        chk("mdl_l2_dat_m", bus.l2_dat_m, e_dm);
        chk("mdl_m_ack", bus.m_ack, e_ack);
        chk("mdl_m_rty", bus.m_rty, e_rty);
        chk("mdl_m_dat_s", bus.m_dat_s, e_ds);
        chk("mdl_gnt", bus.gnt, e_gnt);

        // Advance to the state that holds after the coming rising edge.
        if (rst) begin
          md_conn = 1'b0; md_setup = 1'b0; md_last = N - 1; md_cnt = 0;
        end else if (md_setup) begin
          md_setup = 1'b0; md_conn = 1'b1; md_cnt = 0;
        end else if (md_conn) begin
          if (md_to) begin
            md_conn = 1'b0; md_last = md_own;
          end else if (bus.l2_ack || bus.l2_rty) begin
            md_conn = 1'b0; md_last = md_own;
            md_w = pick(bus.m_cyc & bus.m_stb, md_own, md_own);
            if (md_w >= 0) begin md_setup = 1'b1; md_own = md_w; end
          end else if (!bus.m_cyc[md_own]) begin
            md_conn = 1'b0;
          end else begin
            md_cnt++;
          end
        end else begin
          md_w = pick(bus.m_cyc & bus.m_stb, md_last, -1);
          if (md_w >= 0) begin md_setup = 1'b1; md_own = md_w; end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int order[$];
  int fexp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    clear_inputs();
    step();
    chk_en = 1'b1;
    step();
    settle();
    chk("rst_gnt", bus.gnt, '0);
    chk("rst_l2_cyc", bus.l2_cyc, 1'b0);
    chk("rst_m_ack", bus.m_ack, '0);
    rst = 1'b0;

    // Single read by master 0, ack at cycle 4.
    req(0, 1'b1, 1'b0);                                   // cycle 0
    settle(); chk("t1_c0_l2_cyc", bus.l2_cyc, 1'b0);
    step(); settle();                                     // cycle 1
    chk("t1_c1_l2_cyc", bus.l2_cyc, 1'b0);
    chk("t1_c1_gnt", bus.gnt, '0);
    step(); settle();                                     // cycle 2
    chk("t1_c2_l2_cyc", bus.l2_cyc, 1'b1);
    chk("t1_c2_gnt", bus.gnt, 4'b0001);
    chk("t1_c2_l2_adr", bus.l2_adr, 12'h101);
    step(); settle();                                     // cycle 3
    chk("t1_c3_l2_cyc", bus.l2_cyc, 1'b1);
    chk("t1_c3_m_ack", bus.m_ack, '0);
    step();                                               // cycle 4
    bus.l2_ack = 1'b1; bus.l2_dat_s = 32'hA5A5_A5A5;
    settle();
    chk("t1_c4_l2_cyc", bus.l2_cyc, 1'b1);
    chk("t1_c4_m_ack", bus.m_ack, 4'b0001);
    chk("t1_c4_m_dat_s", bus.m_dat_s, {96'h0, 32'hA5A5_A5A5});
    step();                                               // cycle 5
    bus.l2_ack = 1'b0; req(0, 1'b0, 1'b0);
    settle();
    chk("t1_c5_gnt", bus.gnt, '0);
    chk("t1_c5_l2_cyc", bus.l2_cyc, 1'b0);
    step(); step();

    // Simultaneous requests from 0 and 1 after reset; master 1 finishes with rty.
    do_reset();
    req(0, 1'b1, 1'b0); req(1, 1'b1, 1'b1);               // cycle 0
    step(); step();                                       // cycle 2
    bus.l2_ack = 1'b1; settle();
    chk("t2_c2_gnt", bus.gnt, 4'b0001);
    step();                                               // cycle 3
    bus.l2_ack = 1'b0; req(0, 1'b0, 1'b0); settle();
    chk("t2_c3_gnt", bus.gnt, '0);
    chk("t2_c3_l2_cyc", bus.l2_cyc, 1'b0);
    step();                                               // cycle 4
    bus.l2_rty = 1'b1; settle();
    chk("t2_c4_gnt", bus.gnt, 4'b0010);
    chk("t2_c4_l2_we", bus.l2_we, 1'b1);
    chk("t2_c4_m_rty", bus.m_rty, 4'b0010);
    step();
    bus.l2_rty = 1'b0; req(1, 1'b0, 1'b0);
    step(); step();

    // Fairness: all four request continuously, acked on their first CONNECT cycle.
    do_reset();
    for (int i = 0; i < N; i++) req(i, 1'b1, i[0]);
    for (int c = 0; c < 12; c++) begin
      step();
      bus.l2_ack = |bus.gnt;
      for (int i = 0; i < N; i++) if (bus.gnt[i]) order.push_back(i);
    end
    checks++;
    if (order.size() < 5) begin
      errors++;
      $display("FAIL fair_count: got %0d grants expected at least 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) chk($sformatf("fair_%0d", k), order[k], fexp[k]);
    end
    clear_inputs();
    step(); step(); step(); step();

    // Abort: master 1 drops cyc in its second CONNECT cycle; last_grant must stay 3.
    do_reset();
    req(1, 1'b1, 1'b0);                                   // cycle 0
    step(); step(); settle();                             // cycle 2
    chk("t4_c2_gnt", bus.gnt, 4'b0010);
    step();                                               // cycle 3
    req(1, 1'b0, 1'b0);
    step(); settle();                                     // cycle 4
    chk("t4_c4_l2_cyc", bus.l2_cyc, 1'b0);
    chk("t4_c4_gnt", bus.gnt, '0);
    req(0, 1'b1, 1'b0); req(2, 1'b1, 1'b0);
    step(); step();                                       // cycle 6
    bus.l2_ack = 1'b1; settle();
    chk("t4_c6_gnt", bus.gnt, 4'b0001);
    step();                                               // cycle 7
    bus.l2_ack = 1'b0; req(0, 1'b0, 1'b0);
    step(); settle();                                     // cycle 8: master 2 connected

    // Reset mid-CONNECT; afterwards master 0 must win over master 2 again.
    chk("t5_c8_gnt", bus.gnt, 4'b0100);
    rst = 1'b1;
    step();                                               // cycle 9
    rst = 1'b0; bus.l2_ack = 1'b1; req(0, 1'b1, 1'b0);
    settle();
    chk("t5_c9_l2_cyc", bus.l2_cyc, 1'b0);
    chk("t5_c9_gnt", bus.gnt, '0);
    chk("t5_c9_m_ack", bus.m_ack, '0);
    step();                                               // cycle 10
    bus.l2_ack = 1'b0;
    step();                                               // cycle 11
    bus.l2_ack = 1'b1; settle();
    chk("t5_c11_gnt", bus.gnt, 4'b0001);
    step();
    bus.l2_ack = 1'b0; req(0, 1'b0, 1'b0);
    step();
    bus.l2_ack = 1'b1;
    step();
    bus.l2_ack = 1'b0; req(2, 1'b0, 1'b0);
    step(); step();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog: l2 never responds to master 3.
    do_reset();
    req(3, 1'b1, 1'b0);                                   // cycle 0
    repeat (9) step();                                    // cycle 9
    settle();
    chk("t6_c9_m_rty", bus.m_rty, '0);
    chk("t6_c9_l2_cyc", bus.l2_cyc, 1'b1);
    step(); settle();                                     // cycle 10
    chk("t6_c10_m_rty", bus.m_rty, 4'b1000);
    chk("t6_c10_l2_cyc", bus.l2_cyc, 1'b0);
    step();                                               // cycle 11
    req(3, 1'b0, 1'b0); settle();
    chk("t6_c11_m_rty", bus.m_rty, '0);
    chk("t6_c11_gnt", bus.gnt, '0);
    step(); step();
`endif

    @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
